// File: rtl/systolic_feeder_if.sv
// Load/stream bus between a matrix producer, the systolic feeder and the array's row inputs.
interface systolic_feeder_if #(
  parameter int unsigned DIM     = 8,
  parameter int unsigned BITS_AB = 8
) ();
  localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned BUS_W = DIM * BITS_AB;

  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [BUS_W-1:0] wr_data;
  logic             start;
  logic             en;
  logic             busy;
  logic             valid_out;
  logic             done;
  logic [BUS_W-1:0] A_out;

  modport master (
    output wr_en, wr_row, wr_data, start, en,
    input  busy, valid_out, done, A_out
  );

  modport slave (
    input  wr_en, wr_row, wr_data, start, en,
    output busy, valid_out, done, A_out
  );
endinterface

// File: rtl/systolic_feeder.sv
// Holds a DIM x DIM operand matrix and streams it diagonally skewed into the rows
// of a systolic array: lane i carries row i delayed by i beats.
module systolic_feeder #(
  parameter int unsigned DIM     = 8,
  parameter int unsigned BITS_AB = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);

  localparam int unsigned ROW_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned BUS_W  = DIM * BITS_AB;
  localparam int unsigned LAST_T = 2 * DIM - 2;
  localparam int unsigned T_W    = $clog2(2 * DIM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [T_W-1:0]     r_t;
  logic               r_last;
  logic [BITS_AB-1:0] r_mem [DIM][DIM];
  logic [BUS_W-1:0]   r_a_out;
  logic               r_valid;
  logic               r_done;

  state_t             w_state_nxt;
  logic [T_W-1:0]     w_t_nxt;
  logic               w_last_nxt;
  logic [BUS_W-1:0]   w_a_nxt;
  logic               w_valid_nxt;
  logic               w_done_nxt;
  logic [BUS_W-1:0]   w_beat;
  logic               w_wr_ok;

  // Writes land only while idle so a running stream always sees a stable matrix.
  assign w_wr_ok = bus.wr_en && (r_state == ST_IDLE) && (int'(bus.wr_row) < int'(DIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DIM); i++) begin
        for (int j = 0; j < int'(DIM); j++) begin
          r_mem[ROW_W'(i)][ROW_W'(j)] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      for (int j = 0; j < int'(DIM); j++) begin
        r_mem[bus.wr_row][ROW_W'(j)] <= bus.wr_data[j*BITS_AB +: BITS_AB];
      end
    end
  end

  // Beat t: lane i shows M[i][t-i] inside the diagonal band, zero outside it.
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      int d;
      d = int'(r_t) - i;
      if (d >= 0 && d < int'(DIM)) begin
        w_beat[i*BITS_AB +: BITS_AB] = r_mem[ROW_W'(i)][ROW_W'(d)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_last  <= 1'b0;
      r_a_out <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_last  <= w_last_nxt;
      r_a_out <= w_a_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // r_last marks that the final beat is on A_out; the next en=1 edge retires it into DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_last_nxt  = r_last;
    w_a_nxt     = r_a_out;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_a_nxt     = '0;
        w_valid_nxt = 1'b0;
        if (bus.start) begin
          w_state_nxt = ST_STREAM;
          w_t_nxt     = '0;
          w_last_nxt  = 1'b0;
        end
      end

      ST_STREAM: begin
        if (bus.en) begin
          if (r_last) begin
            w_state_nxt = ST_DONE;
            w_a_nxt     = '0;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_a_nxt     = w_beat;
            w_valid_nxt = 1'b1;
            if (r_t == T_W'(LAST_T)) begin
              w_last_nxt = 1'b1;
            end else begin
              w_t_nxt = r_t + T_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_t_nxt     = '0;
        w_last_nxt  = 1'b0;
        w_a_nxt     = '0;
        w_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_t_nxt     = '0;
        w_last_nxt  = 1'b0;
        w_a_nxt     = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.busy      = (r_state == ST_STREAM);
  assign bus.valid_out = r_valid;
  assign bus.done      = r_done;
  assign bus.A_out     = r_a_out;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: driver pushes expected skewed beats, a negedge monitor retires them.
module tb_systolic_feeder;

  localparam int DIM     = 4;
  localparam int BITS_AB = 8;
  localparam int ROW_W   = 2;
  localparam int BUS_W   = DIM * BITS_AB;
  localparam int NBEATS  = 2 * DIM - 1;

  typedef struct {
    bit               is_done;
    logic [BUS_W-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  systolic_feeder_if #(.DIM(DIM), .BITS_AB(BITS_AB)) bus ();

  systolic_feeder #(.DIM(DIM), .BITS_AB(BITS_AB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fails   = 0;
  int done_seen = 0;

  exp_t             exp_q[$];
  logic [BUS_W-1:0] run_log[$];
  logic [BUS_W-1:0] saved_log[$];
  logic [BITS_AB-1:0] m_mem [DIM][DIM];
  bit               m_active = 1'b0;

  task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: lane i is row i of the matrix, padded with i leading zeros.
  task automatic push_stream();
    logic [BITS_AB-1:0] seq [DIM][NBEATS];
    logic [BUS_W-1:0]   b;
    exp_t               e;
    for (int i = 0; i < DIM; i++) begin
      for (int t = 0; t < NBEATS; t++) seq[i][t] = '0;
      for (int j = 0; j < DIM; j++) seq[i][i + j] = m_mem[i][j];
    end
    for (int t = 0; t < NBEATS; t++) begin
      b = '0;
      for (int i = 0; i < DIM; i++) b[i*BITS_AB +: BITS_AB] = seq[i][t];
      e.is_done = 1'b0;
      e.data    = b;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.data    = '0;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; the model applies what the DUT samples at the coming edge.
  task automatic drive_cycle(input bit we, input int row, input logic [BUS_W-1:0] data,
                             input bit st, input bit e);
    bus.wr_en   = we;
    bus.wr_row  = ROW_W'(row);
    bus.wr_data = data;
    bus.start   = st;
    bus.en      = e;
    if (rst_n && we && !m_active) begin
      for (int j = 0; j < DIM; j++) m_mem[row][j] = data[j*BITS_AB +: BITS_AB];
    end
    if (rst_n && st && !m_active) begin
      m_active = 1'b1;
      run_log.delete();
      push_stream();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_random();
    for (int r = 0; r < DIM; r++) drive_cycle(1'b1, r, BUS_W'($urandom), 1'b0, 1'b0);
  endtask

  // mode 1 randomizes en; stall_beat holds en low twice while that beat is shown;
  // inject 1 writes, inject 2 re-starts, partway through the stream.
  task automatic run_stream(input int mode, input int stall_beat, input int inject);
    int base   = done_seen;
    int stalls = 0;
    bit ok     = 1'b0;
    bit e;
    for (int c = 0; c < 300; c++) begin
      if (done_seen > base) begin
        ok = 1'b1;
        break;
      end
      e = 1'b1;
      if (mode == 1) e = ($urandom_range(0, 3) != 0);
      if (stall_beat >= 0 && run_log.size() == stall_beat && bus.valid_out && stalls < 2) begin
        e = 1'b0;
        stalls++;
      end
      drive_cycle(inject == 1 && c == 3, 0, BUS_W'($urandom), inject == 2 && c == 3, e);
    end
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL stream_timeout: got no done pulse, expected one within 300 cycles");
    end
    check("beat_count", BUS_W'(run_log.size()), BUS_W'(NBEATS));
    check("queue_drained", BUS_W'(exp_q.size()), '0);
    check("idle_busy", BUS_W'(bus.busy), '0);
  endtask

  // Monitor: a beat is retired on the edge where valid_out and en are both high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_out) begin
        check("valid_done_excl", BUS_W'(bus.done), '0);
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_beat: got %h, expected no beat", bus.A_out);
        end else if (bus.en) begin
          check("beat", bus.A_out, exp_q[0].data);
          run_log.push_back(bus.A_out);
          void'(exp_q.pop_front());
        end else begin
          check("stall_hold", bus.A_out, exp_q[0].data);
        end
      end else if (bus.done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_done: got done=1, expected %0d more beats", exp_q.size());
        end else begin
          void'(exp_q.pop_front());
          check("done_a_out", bus.A_out, '0);
          check("done_busy", BUS_W'(bus.busy), '0);
          m_active = 1'b0;
          done_seen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUS_W-1:0] d;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_row  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.en      = 1'b0;
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) m_mem[i][j] = '0;
    #2;
    check("rst_a_out", bus.A_out, '0);
    check("rst_valid", BUS_W'(bus.valid_out), '0);
    check("rst_done", BUS_W'(bus.done), '0);
    check("rst_busy", BUS_W'(bus.busy), '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp matrix M[i][j] = 16*i + j, loaded starting on the first edge after reset.
    for (int r = 0; r < DIM; r++) begin
      d = '0;
      for (int j = 0; j < DIM; j++) d[j*BITS_AB +: BITS_AB] = BITS_AB'(16 * r + j);
      drive_cycle(1'b1, r, d, 1'b0, 1'b0);
    end
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    check("lat_busy", BUS_W'(bus.busy), 1);
    check("lat_valid_early", BUS_W'(bus.valid_out), '0);
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b1);
    check("lat_valid_beat0", BUS_W'(bus.valid_out), 1);
    run_stream(0, -1, 0);
    if (run_log.size() == NBEATS) begin
      check("ramp_beat0", run_log[0], 32'h00000000);
      check("ramp_beat3", run_log[3], 32'h30211203);
      check("ramp_beat6", run_log[6], 32'h33000000);
    end
    saved_log = run_log;

    // Stall at beat 2, then a write attempted mid-stream must leave M untouched.
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    run_stream(0, 2, 1);
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    run_stream(0, -1, 0);
    if (run_log.size() == NBEATS) check("rerun_beat3", run_log[3], saved_log[3]);

    // Start during stream is ignored; only one done pulse is allowed.
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    run_stream(0, -1, 2);

    // Signed extreme value passes bit-exact.
    load_random();
    d = BUS_W'($urandom);
    d[1*BITS_AB +: BITS_AB] = 8'h80;
    drive_cycle(1'b1, 2, d, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    run_stream(1, -1, 0);
    if (run_log.size() == NBEATS) check("signed_lane2_beat3", BUS_W'(run_log[3][23:16]), 32'h80);

    // Write and start in the same idle cycle: the stream uses the new row.
    d = BUS_W'($urandom);
    drive_cycle(1'b1, 1, d, 1'b1, 1'b1);
    run_stream(0, -1, 0);
    if (run_log.size() == NBEATS) check("wr_start_lane1_beat1", BUS_W'(run_log[1][15:8]), BUS_W'(d[7:0]));

    for (int k = 0; k < 4; k++) begin
      load_random();
      drive_cycle(1'b0, 0, '0, 1'b1, 1'b0);
      run_stream(1, -1, 0);
    end

    // Asynchronous reset while beat 4 is on the bus.
    load_random();
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 50 && run_log.size() < 4; c++) drive_cycle(1'b0, 0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_a_out", bus.A_out, '0);
    check("arst_valid", BUS_W'(bus.valid_out), '0);
    check("arst_done", BUS_W'(bus.done), '0);
    check("arst_busy", BUS_W'(bus.busy), '0);
    exp_q.delete();
    m_active = 1'b0;
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) m_mem[i][j] = '0;
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (6) drive_cycle(1'b0, 0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b1);
    run_stream(0, -1, 0);
    for (int t = 0; t < run_log.size(); t++) check("post_rst_zero", run_log[t], '0);

    repeat (3) drive_cycle(1'b0, 0, '0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
